maze_mem_arbiter: RTL

Shares the single-port 64×2-bit maze map memory between two requesters: a write port (map loader / game logic) and a row-burst read port (LED matrix scanner). Sequences each granted access onto the memory's address/write-enable/data bus, performs 8-cell row bursts for the display side, and arbitrates round-robin when both request together. Sits between the memory instance and its clients in the top-level maze design, replacing direct multi-driver access to the memory bus.

---
 rtl/maze_mem_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/maze_mem_arbiter.sv
// Arbitrates the maze map memory between a single-cell writer and an 8-cell row reader (round-robin on ties).
// Write takes 1 cycle and read delivers rd_valid 10 cycles after grant; requests hold until acked and are never preempted.
module maze_mem_arbiter #(
    parameter int DATA_W  = 2,
    parameter int ADDR_W  = 6,
    parameter int ROW_LEN = 8
) (
    input  logic                                  clk,
    input  logic                                  nst,
    input  logic                                  wr_req,
    input  logic [ADDR_W-1:0]                     wr_addr,
    input  logic [DATA_W-1:0]                     wr_data,
    output logic                                  wr_ack,
    input  logic                                  rd_req,
    input  logic [ADDR_W-$clog2(ROW_LEN)-1:0]     rd_row,
    output logic                                  rd_valid,
    output logic [DATA_W*ROW_LEN-1:0]             rd_line,
    output logic [ADDR_W-1:0]                     mem_addr,
    output logic                                  mem_we,
    output logic [DATA_W-1:0]                     mem_wdata,
    input  logic [DATA_W-1:0]                     mem_rdata,
    output logic                                  busy
);
    localparam int COL_W = $clog2(ROW_LEN);
    localparam int ROW_W = ADDR_W - COL_W;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_LEN - 1);

    typedef enum logic [1:0] {IDLE, WRITE, BURST, DRAIN} state_t;
    typedef enum logic {GNT_WRITE, GNT_READ} grant_t;

    state_t                          state_q;
    grant_t                          last_grant_q;
    logic [ROW_W-1:0]                row_q;
    logic [COL_W-1:0]                col_q;
    logic [DATA_W*(ROW_LEN-1)-1:0]   stage_q;
    logic [DATA_W*ROW_LEN-1:0]       rd_line_q;
    logic                            wr_ack_q;
    logic                            rd_valid_q;
    logic [ADDR_W-1:0]               mem_addr_q;
    logic                            mem_we_q;
    logic [DATA_W-1:0]               mem_wdata_q;

    logic                            grant_wr_d;
    logic                            grant_rd_d;
    logic [COL_W-1:0]                col_next_d;
    logic [COL_W-1:0]                col_prev_d;

    // On a tie the writer wins only if the reader was served last.
    assign grant_wr_d = wr_req && (!rd_req || (last_grant_q == GNT_READ));
    assign grant_rd_d = rd_req && !grant_wr_d;
    assign col_next_d = col_q + COL_W'(1);
    assign col_prev_d = col_q - COL_W'(1);

    always_ff @(posedge clk or posedge nst) begin
        if (nst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_READ;
            row_q        <= '0;
            col_q        <= '0;
            stage_q      <= '0;
            rd_line_q    <= '0;
            wr_ack_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            wr_ack_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            case (state_q)
                IDLE: begin
                    mem_addr_q <= '0;
                    col_q      <= '0;
                    if (grant_wr_d) begin
                        state_q     <= WRITE;
                        wr_ack_q    <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= wr_addr;
                        mem_wdata_q <= wr_data;
                    end else if (grant_rd_d) begin
                        state_q    <= BURST;
                        row_q      <= rd_row;
                        mem_addr_q <= {rd_row, {COL_W{1'b0}}};
                    end
                end
                WRITE: begin
                    state_q      <= IDLE;
                    mem_addr_q   <= '0;
                    last_grant_q <= GNT_WRITE;
                end
                BURST: begin
                    // Read data lags its address by one cycle, so capture the previous column.
                    if (col_q != '0) begin
                        for (int i = 0; i < ROW_LEN - 1; i++) begin
                            if (col_prev_d == COL_W'(i)) begin
                                stage_q[DATA_W*i +: DATA_W] <= mem_rdata;
                            end
                        end
                    end
                    if (col_q == LAST_COL) begin
                        state_q <= DRAIN;
                    end else begin
                        col_q      <= col_next_d;
                        mem_addr_q <= {row_q, col_next_d};
                    end
                end
                DRAIN: begin
                    rd_line_q    <= {mem_rdata, stage_q};
                    rd_valid_q   <= 1'b1;
                    state_q      <= IDLE;
                    mem_addr_q   <= '0;
                    col_q        <= '0;
                    last_grant_q <= GNT_READ;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_ack    = wr_ack_q;
    assign rd_valid  = rd_valid_q;
    assign rd_line   = rd_line_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);
endmodule
